data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words of storage; it SHALL be a power of two.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, giving the number of extra wait cycles per access; legal range is 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-005 The block SHALL have port req_valid, input, 1 bit: the core presents an access.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept an access this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port req_size, input, 3 bits: RV32I funct3 of the load or store.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: extended load result.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the access was rejected and had no effect.

Function
REQ-014 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 An access SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_size SHALL be captured into registers at that edge.
REQ-017 On acceptance: IDLE SHALL go to WAIT if WAIT_CYCLES>0, else to RESP; WAIT SHALL count down WAIT_CYCLES cycles and then go to RESP; RESP SHALL last one cycle and then go to IDLE.
REQ-018 rsp_valid SHALL be 1 exactly during RESP; for an access accepted at edge T it SHALL be high in cycle T+1+WAIT_CYCLES, with no backpressure.
REQ-019 req_valid arriving outside IDLE SHALL be ignored; the core must hold the request until it is accepted.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so accesses wrap modulo the memory size.
REQ-021 Loads SHALL be decoded from req_size: 000 = LB sign-extended, 001 = LH sign-extended, 010 = LW, 100 = LBU zero-extended, 101 = LHU zero-extended.
REQ-022 Byte and halfword loads SHALL select the lane from addr[1:0] and present it right-aligned on rsp_rdata.
REQ-023 Stores SHALL be decoded from req_size: 000 = SB, 001 = SH, 010 = SW; a store SHALL write only the addressed byte lanes.
REQ-024 A store SHALL commit on the edge that leaves RESP, and its rsp_rdata SHALL be 0.
REQ-025 Load data SHALL be read in RESP, so a load accepted after a store returns the stored value.
REQ-026 Any other req_size code (011, 110, 111, and 1xx for stores) SHALL set rsp_err=1 and rsp_rdata=0 with no write; it SHALL take the same latency.
REQ-027 rsp_err and rsp_rdata SHALL be 0 whenever rsp_valid=0.
REQ-028 Memory contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-029 While reset=0 the block SHALL hold state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-030 Reset asserted in WAIT or RESP SHALL abort the access; a pending store SHALL NOT be written and no response SHALL be issued.
REQ-031 The first access SHALL be accepted on the first rising edge after reset is released.

Configuration
REQ-032 The macro DMEM_MISALIGN_CHECK_EN SHALL control misaligned-access checking.
REQ-033 With DMEM_MISALIGN_CHECK_EN defined, a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL complete with rsp_err=1, rsp_rdata=0 and no write.
REQ-034 Without DMEM_MISALIGN_CHECK_EN, misaligned accesses SHALL force the offending low address bits to 0, complete with rsp_err=0, and access the aligned location.

Verification
REQ-035 The bench SHALL cover: after reset, with WAIT_CYCLES=1, SW 0xDEADBEEF to 0x10 accepted at edge T, then rsp_valid=1 only in cycle T+2 with rsp_rdata=0; a following LW 0x10 returns 0xDEADBEEF.
REQ-036 The bench SHALL cover: after the word above, SB 0x7F to 0x11, then LW 0x10 -> 0xDEAD7FEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD.
REQ-037 The bench SHALL cover: with DEPTH_WORDS=256, SW 0x12345678 to 0x400, then LW 0x000 -> 0x12345678 (wrap-around).
REQ-038 The bench SHALL cover: req_valid held through WAIT -> exactly one response, with req_ready=0 until RESP has ended; a back-to-back request is accepted on the edge after RESP.
REQ-039 The bench SHALL cover: reset pulsed low during WAIT of SW 0xAAAAAAAA to 0x20 -> no rsp_valid, and a later LW 0x20 returns the previous contents.
REQ-040 The bench SHALL cover: LW to 0x22 -> rsp_err=1 with the macro defined; without the macro -> rsp_err=0 and the data of 0x20; size code 011 -> rsp_err=1 in both builds.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Core-to-data-memory request/response bundle.
// master drives req_*; slave returns req_ready and rsp_*.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32I data memory controller: one access at a time, IDLE->WAIT->RESP.
// Ports: clk, reset (async, active-low), bus (data_mem_ctrl_if.slave).
// Macro DMEM_MISALIGN_CHECK_EN: misaligned half/word -> rsp_err.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            reset,
  data_mem_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    size_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          sz_ok;
  logic          mis;
  logic          err;
  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   lane;
  logic [31:0]   ext;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          wr_en;

  // High address bits are deliberately dropped: accesses wrap.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[31:AW+2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[AW+1:0];
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // Loads: 000,001,010,100,101. Stores: 000,001,010.
    if (we_q)
      sz_ok = !size_q[2] && (size_q[1:0] != 2'b11);
    else
      sz_ok = (size_q[1:0] != 2'b11) && !(size_q[2] && size_q[1]);

    mis = (size_q[1:0] == 2'b01 && addr_q[0]) ||
          (size_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_CHECK_EN
    err = !sz_ok || mis;
`else
    err = !sz_ok;
`endif

    // Lane offset with misaligned low bits forced to zero.
    off = 2'b00;
    unique case (1'b1)
      size_q[1:0] == 2'b00: off = addr_q[1:0];
      size_q[1:0] == 2'b01: off = {addr_q[1], 1'b0};
      default:              off = 2'b00;
    endcase

    idx  = addr_q[AW+1:2];
    word = mem[idx];
    lane = word >> {off, 3'b000};

    ext = word;
    unique case (size_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = word;
    endcase

    be = 4'b1111;
    wd = wdata_q;
    unique case (1'b1)
      size_q[1:0] == 2'b00: begin
        be = 4'b0001 << off;
        wd = {4{wdata_q[7:0]}};
      end
      size_q[1:0] == 2'b01: begin
        be = 4'b0011 << off;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_q;
      end
    endcase

    // reset gate keeps an aborted store from landing.
    wr_en = (state == RESP) && we_q && !err && reset;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && err;
  assign bus.rsp_rdata =
    ((state == RESP) && !we_q && !err) ? ext : 32'd0;

endmodule
